// File: rtl/dpram_lsu.sv
// Load/store initiator for port B of the data dual-port RAM.
// One RV32 load/store at a time; single-cycle response pulse, errors never reach the RAM.
module dpram_lsu #(
    parameter int unsigned RAM_DEPTH = 2048,
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
    localparam int unsigned ADDR_W   = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [31:0]       rsp_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [3:0]        ram_wem,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_din,
    input  logic [31:0]       ram_dout
);

    localparam longint unsigned SPAN = 64'(RAM_DEPTH) * 64'd4;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_t;

    state_t      state, state_nxt;
    logic        accept;
    logic        req_err;
    logic        in_range;
    logic [31:0] offset;
    logic [31:0] st_din;
    logic [3:0]  st_wem;
    logic        we_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [1:0]  lo_q;
    logic [3:0]  wem_q;
    logic [31:0] shifted;
    logic [31:0] load_data;

    assign accept   = req_valid && (state == S_IDLE);
    assign offset   = req_addr - BASE_ADDR;
    assign in_range = (req_addr >= BASE_ADDR) && ({32'b0, offset} < SPAN);

    always_comb begin
        req_err = 1'b0;
        case (req_size)
            2'b00:   req_err = 1'b0;
            2'b01:   req_err = req_addr[0];
            2'b10:   req_err = |req_addr[1:0];
            default: req_err = 1'b1;
        endcase
        if (!in_range) req_err = 1'b1;
    end

    always_comb begin
        st_din = req_wdata;
        st_wem = 4'b1111;
        case (req_size)
            2'b00: begin
                st_din = {4{req_wdata[7:0]}};
                st_wem = 4'b0001 << req_addr[1:0];
            end
            2'b01: begin
                st_din = {2{req_wdata[15:0]}};
                st_wem = req_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_din = req_wdata;
                st_wem = 4'b1111;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (accept) state_nxt = req_err ? S_RESP : S_ACCESS;
            S_ACCESS: state_nxt = we_q ? S_RESP : S_WAIT;
            S_WAIT:   state_nxt = S_RESP;
            S_RESP:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Strobes decode straight from the state register so reset kills the write mask at once.
    always_comb begin
        req_ready = (state == S_IDLE);
        rsp_valid = (state == S_RESP);
        ram_en    = (state == S_ACCESS);
        ram_we    = (state == S_ACCESS) && we_q;
        ram_wem   = (state == S_ACCESS) ? wem_q : '0;
    end

    always_comb begin
        shifted   = ram_dout >> {lo_q, 3'b000};
        load_data = shifted;
        case (size_q)
            2'b00:   load_data = uns_q ? {24'b0, shifted[7:0]}
                                       : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   load_data = uns_q ? {16'b0, shifted[15:0]}
                                       : {{16{shifted[15]}}, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q      <= 1'b0;
            size_q    <= '0;
            uns_q     <= 1'b0;
            lo_q      <= '0;
            wem_q     <= '0;
            ram_addr  <= '0;
            ram_din   <= '0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            if (accept) begin
                we_q   <= req_we;
                size_q <= req_size;
                uns_q  <= req_unsigned;
                lo_q   <= req_addr[1:0];
                wem_q  <= req_we ? st_wem : '0;
                if (req_err) begin
                    rsp_err   <= 1'b1;
                    rsp_rdata <= '0;
                end else begin
                    ram_addr <= offset[ADDR_W+1:2];
                    ram_din  <= st_din;
                end
            end
            if (state == S_ACCESS && we_q) begin
                rsp_err   <= 1'b0;
                rsp_rdata <= '0;
            end
            // The port output refreshes every cycle, so only the WAIT sample is the load data.
            if (state == S_WAIT) begin
                rsp_err   <= 1'b0;
                rsp_rdata <= load_data;
            end
        end
    end

endmodule
